lock_sequencer: RTL and testbench
=================================

// Module: lock_sequencer
// PURPOSE
//  Sequences the combination-lock flow: synchronises two raw push-buttons, runs the lock FSM,
//  stores the code, counts failed attempts and enforces a timed lockout. Drives state and
//  indicator outputs for the top-level pin mapping. Replaces ad-hoc per-button edge logic with
//  one clocked controller.
// PARAMETERS
//  PW_W        7      code / stored password width (bits)
//  SYNC_STAGES 2      button synchroniser depth (>=2)
//  MAX_FAILS   3      consecutive wrong codes that trigger LOCKOUT (1..7)
//  LOCKOUT_CYC 50000  LOCKOUT duration in clk cycles (>=1)
//  RELOCK_CYC  60000  auto-relock timeout in clk cycles (>=1); used only with macro
//  BLINK_HALF  5000   alarm_o half-period in clk cycles (>=1)
// PORTS
//  clk          in   1     clock; all state on rising edge
//  rst_n        in   1     asynchronous active-low reset
//  ena          in   1     1 = accept button events; 0 = events dropped, timers keep running
//  btn_set_n    in   1     raw SET button, active-low, asynchronous
//  btn_enter_n  in   1     raw ENTER button, active-low, asynchronous
//  code_i       in   PW_W  code switches; sampled on the press-event cycle
//  state_o      out  3     IDLE=000 SET_AWAITING=001 OPENED=010 ALARM=011 INPUT=100 LOCKOUT=101
//  open_o       out  1     1 iff state OPENED
//  alarm_o      out  1     blink in ALARM, solid 1 in LOCKOUT, else 0
//  pw_valid_o   out  1     1 once a password has been stored
//  fails_o      out  3     consecutive failed attempts
// BEHAVIOUR
//  Reset (async assert, sync deassert to the FSM): state IDLE, password 0, pw_valid_o 0,
//   fails_o 0, timer 0, alarm_o 0, open_o 0, synchroniser flops 1 (released).
//  Press event: one-cycle pulse when the last sync stage goes 1->0 and ena=1. Raw falling
//   edge -> state_o update on rising edge SYNC_STAGES+1 after the first sampling edge.
//  Same-cycle SET and ENTER events: ENTER wins, SET dropped.
//  Transitions (events not listed are ignored):
//   IDLE:         ENTER -> INPUT
//   INPUT:        ENTER -> compare code_i with password; pw_valid_o=0 counts as a match.
//                 match -> OPENED, fails=0. Mismatch -> fails+1; new fails==MAX_FAILS ->
//                 LOCKOUT, timer=LOCKOUT_CYC-1, else -> ALARM.
//   OPENED:       SET -> SET_AWAITING;  ENTER -> IDLE
//   SET_AWAITING: SET -> password=code_i, pw_valid_o=1, -> IDLE;
//                 ENTER -> IDLE, password unchanged
//   ALARM:        ENTER -> IDLE (fails kept)
//   LOCKOUT:      all events ignored; timer decrements each cycle; at timer==0 -> IDLE, fails=0
//  fails_o saturates at MAX_FAILS; cleared only by match, lockout expiry or reset.
//  Blink: entering ALARM sets alarm_o=1 and clears the prescaler; alarm_o toggles every
//   BLINK_HALF cycles while in ALARM; drops to 0 on the exit cycle.
//  Timer and prescaler are 16-bit; parameters above 65535 are illegal.
//  Outputs are registered or decoded from registered state; no comb path from inputs.
//  Reset mid-operation (any state, timer running): immediate return to reset values;
//   stored password lost.
// CONFIGURATION
//  LOCK_SEQ_AUTORELOCK_EN defined: entering OPENED or SET_AWAITING loads timer=RELOCK_CYC-1;
//   timer decrements; at 0 with no event -> IDLE (password unchanged). An event on the expiry
//   cycle takes priority over the timeout.
//  Undefined: OPENED and SET_AWAITING hold indefinitely; timer used only by LOCKOUT.
// TESTING  (bench params: MAX_FAILS=3, LOCKOUT_CYC=20, RELOCK_CYC=30, BLINK_HALF=4)
//  Reset, ENTER, ENTER with code 7'h55 -> OPENED, open_o=1 (unprogrammed matches any code)
//  OPENED, SET, code 7'h2A, SET -> IDLE, pw_valid_o=1; ENTER, ENTER with 7'h2A -> OPENED
//  Stored 7'h2A, enter 7'h11 -> ALARM, fails_o=1, alarm_o toggles every 4 cycles; ENTER -> IDLE
//  3 wrong codes -> LOCKOUT, alarm_o=1, presses ignored, IDLE after exactly 20 cycles, fails_o=0
//  SET and ENTER in same cycle while OPENED -> IDLE, password unchanged
//  AUTORELOCK_EN: hold OPENED with no presses -> IDLE after 30 cycles; undefined: OPENED held;
//   rst_n low during LOCKOUT -> IDLE, pw_valid_o=0

Source files
------------

// File: rtl/lock_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | lock_sequencer: button sync, lock FSM, password store, fail count, timed lockout.     |
// | Optional LOCK_SEQ_AUTORELOCK_EN: OPENED/SET_AWAITING time out back to IDLE.           |
// | Rev 1.0                                                                              |
// +--------------------------------------------------------------------------------------+
module lock_sequencer #(
  parameter int PW_W        = 7,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_FAILS   = 3,
  parameter int LOCKOUT_CYC = 50000,
  parameter int RELOCK_CYC  = 60000,
  parameter int BLINK_HALF  = 5000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            btn_set_n,
  input  logic            btn_enter_n,
  input  logic [PW_W-1:0] code_i,
  output logic [2:0]      state_o,
  output logic            open_o,
  output logic            alarm_o,
  output logic            pw_valid_o,
  output logic [2:0]      fails_o
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'b000,
    S_SET_AWAITING = 3'b001,
    S_OPENED       = 3'b010,
    S_ALARM        = 3'b011,
    S_INPUT        = 3'b100,
    S_LOCKOUT      = 3'b101
  } state_t;

`ifdef LOCK_SEQ_AUTORELOCK_EN
  localparam bit C_AUTORELOCK = 1'b1;
`else
  localparam bit C_AUTORELOCK = 1'b0;
`endif

  localparam logic [2:0]  C_MAX_FAILS    = 3'(MAX_FAILS);
  localparam logic [15:0] C_LOCKOUT_LOAD = 16'(LOCKOUT_CYC - 1);
  localparam logic [15:0] C_RELOCK_LOAD  = 16'(RELOCK_CYC - 1);
  localparam logic [15:0] C_BLINK_LAST   = 16'(BLINK_HALF - 1);

  logic [SYNC_STAGES-1:0] r_set_sync, r_enter_sync;
  logic                   r_set_last, r_enter_last;
  logic                   w_set_evt, w_enter_evt, w_set, w_enter;

  state_t         r_state, w_state_nx;
  logic [PW_W-1:0] r_pw, w_pw_nx;
  logic           r_pw_valid, w_pw_valid_nx;
  logic [2:0]     r_fails, w_fails_nx, w_fails_inc;
  logic [15:0]    r_timer, w_timer_nx;
  logic [15:0]    r_presc, w_presc_nx;
  logic           r_alarm, w_alarm_nx;
  logic           w_match;

  // Buttons idle high; the extra flop after the last stage gives the 1->0 edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_sync   <= '1;
      r_enter_sync <= '1;
      r_set_last   <= 1'b1;
      r_enter_last <= 1'b1;
    end else begin
      r_set_sync   <= {r_set_sync[SYNC_STAGES-2:0], btn_set_n};
      r_enter_sync <= {r_enter_sync[SYNC_STAGES-2:0], btn_enter_n};
      r_set_last   <= r_set_sync[SYNC_STAGES-1];
      r_enter_last <= r_enter_sync[SYNC_STAGES-1];
    end
  end

  assign w_set_evt   = ena & r_set_last & ~r_set_sync[SYNC_STAGES-1];
  assign w_enter_evt = ena & r_enter_last & ~r_enter_sync[SYNC_STAGES-1];
  assign w_enter     = w_enter_evt;
  assign w_set       = w_set_evt & ~w_enter_evt;

  assign w_match     = ~r_pw_valid | (code_i == r_pw);
  assign w_fails_inc = (r_fails >= C_MAX_FAILS) ? C_MAX_FAILS : r_fails + 3'd1;

  always_comb begin
    w_state_nx    = r_state;
    w_pw_nx       = r_pw;
    w_pw_valid_nx = r_pw_valid;
    w_fails_nx    = r_fails;
    w_timer_nx    = r_timer;
    w_presc_nx    = r_presc;
    w_alarm_nx    = 1'b0;

    case (r_state)
      S_IDLE: if (w_enter) w_state_nx = S_INPUT;
      S_INPUT: begin
        if (w_enter) begin
          if (w_match) begin
            w_state_nx = S_OPENED;
            w_fails_nx = 3'd0;
          end else begin
            w_fails_nx = w_fails_inc;
            if (w_fails_inc == C_MAX_FAILS) begin
              w_state_nx = S_LOCKOUT;
              w_timer_nx = C_LOCKOUT_LOAD;
            end else begin
              w_state_nx = S_ALARM;
            end
          end
        end
      end
      S_OPENED: begin
        if (w_set)                              w_state_nx = S_SET_AWAITING;
        else if (w_enter)                       w_state_nx = S_IDLE;
        else if (C_AUTORELOCK && r_timer == '0) w_state_nx = S_IDLE;
        else if (C_AUTORELOCK)                  w_timer_nx = r_timer - 16'd1;
      end
      S_SET_AWAITING: begin
        if (w_set) begin
          w_pw_nx       = code_i;
          w_pw_valid_nx = 1'b1;
          w_state_nx    = S_IDLE;
        end else if (w_enter) begin
          w_state_nx = S_IDLE;
        end else if (C_AUTORELOCK && r_timer == '0) begin
          w_state_nx = S_IDLE;
        end else if (C_AUTORELOCK) begin
          w_timer_nx = r_timer - 16'd1;
        end
      end
      S_ALARM: if (w_enter) w_state_nx = S_IDLE;
      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_nx = S_IDLE;
          w_fails_nx = 3'd0;
        end else begin
          w_timer_nx = r_timer - 16'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // Relock window restarts whenever a relockable state is freshly entered.
    if (C_AUTORELOCK && (w_state_nx != r_state) &&
        (w_state_nx == S_OPENED || w_state_nx == S_SET_AWAITING))
      w_timer_nx = C_RELOCK_LOAD;

    if (w_state_nx == S_LOCKOUT) begin
      w_alarm_nx = 1'b1;
    end else if (w_state_nx == S_ALARM) begin
      if (r_state != S_ALARM) begin
        w_alarm_nx = 1'b1;
        w_presc_nx = '0;
      end else if (r_presc == C_BLINK_LAST) begin
        w_alarm_nx = ~r_alarm;
        w_presc_nx = '0;
      end else begin
        w_alarm_nx = r_alarm;
        w_presc_nx = r_presc + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pw       <= '0;
      r_pw_valid <= 1'b0;
      r_fails    <= 3'd0;
      r_timer    <= '0;
      r_presc    <= '0;
      r_alarm    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pw       <= w_pw_nx;
      r_pw_valid <= w_pw_valid_nx;
      r_fails    <= w_fails_nx;
      r_timer    <= w_timer_nx;
      r_presc    <= w_presc_nx;
      r_alarm    <= w_alarm_nx;
    end
  end

  assign state_o    = r_state;
  assign open_o     = (r_state == S_OPENED);
  assign alarm_o    = r_alarm;
  assign pw_valid_o = r_pw_valid;
  assign fails_o    = r_fails;

endmodule
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | tb_lock_sequencer: directed self-checking bench for lock_sequencer.                   |
// | Rev 1.0                                                                              |
// +--------------------------------------------------------------------------------------+
module tb_lock_sequencer;
  localparam logic [2:0] IDLE = 3'b000, SETW = 3'b001, OPENED = 3'b010,
                         ALARM = 3'b011, INPUT = 3'b100, LOCKOUT = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n, ena, btn_set_n, btn_enter_n;
  logic [6:0] code_i;
  logic [2:0] state_o, fails_o;
  logic       open_o, alarm_o, pw_valid_o;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  lock_sequencer #(
    .PW_W(7), .SYNC_STAGES(2), .MAX_FAILS(3),
    .LOCKOUT_CYC(20), .RELOCK_CYC(30), .BLINK_HALF(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .btn_set_n(btn_set_n), .btn_enter_n(btn_enter_n), .code_i(code_i),
    .state_o(state_o), .open_o(open_o), .alarm_o(alarm_o),
    .pw_valid_o(pw_valid_o), .fails_o(fails_o)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Returns on the falling edge right after the edge that acts on the press.
  task automatic press(input logic s, input logic e, input logic [6:0] code);
    repeat (3) @(negedge clk);
    code_i      = code;
    btn_set_n   = ~s;
    btn_enter_n = ~e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    btn_set_n   = 1'b1;
    btn_enter_n = 1'b1;
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wrong(input logic [6:0] code);
    press(1'b0, 1'b1, 7'h00);
    press(1'b0, 1'b1, code);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; btn_set_n = 1'b1; btn_enter_n = 1'b1; code_i = 7'h00;
    ticks(3);
    check("rst_state", {5'd0, state_o}, {5'd0, IDLE});
    check("rst_open", {7'd0, open_o}, 8'd0);
    check("rst_alarm", {7'd0, alarm_o}, 8'd0);
    check("rst_pwvalid", {7'd0, pw_valid_o}, 8'd0);
    check("rst_fails", {5'd0, fails_o}, 8'd0);
    rst_n = 1'b1;

    press(1'b0, 1'b1, 7'h00);
    check("idle_enter", {5'd0, state_o}, {5'd0, INPUT});
    press(1'b0, 1'b1, 7'h55);
    check("unprog_open", {5'd0, state_o}, {5'd0, OPENED});
    check("unprog_open_o", {7'd0, open_o}, 8'd1);

    press(1'b1, 1'b0, 7'h2A);
    check("set_await", {5'd0, state_o}, {5'd0, SETW});
    check("set_await_open", {7'd0, open_o}, 8'd0);
    press(1'b1, 1'b0, 7'h2A);
    check("store_idle", {5'd0, state_o}, {5'd0, IDLE});
    check("store_valid", {7'd0, pw_valid_o}, 8'd1);

    press(1'b0, 1'b1, 7'h00);
    press(1'b0, 1'b1, 7'h2A);
    check("good_code", {5'd0, state_o}, {5'd0, OPENED});
    press(1'b0, 1'b1, 7'h00);
    check("open_enter_idle", {5'd0, state_o}, {5'd0, IDLE});

    // Wrong code: alarm high for 4 cycles, low for 4, high again.
    wrong(7'h11);
    check("alarm_state", {5'd0, state_o}, {5'd0, ALARM});
    check("alarm_fails1", {5'd0, fails_o}, 8'd1);
    check("blink_e0", {7'd0, alarm_o}, 8'd1);
    ticks(3);
    check("blink_e3", {7'd0, alarm_o}, 8'd1);
    ticks(1);
    check("blink_e4", {7'd0, alarm_o}, 8'd0);
    ticks(3);
    check("blink_e7", {7'd0, alarm_o}, 8'd0);
    ticks(1);
    check("blink_e8", {7'd0, alarm_o}, 8'd1);
    press(1'b0, 1'b1, 7'h00);
    check("alarm_exit", {5'd0, state_o}, {5'd0, IDLE});
    check("alarm_exit_off", {7'd0, alarm_o}, 8'd0);
    check("alarm_fails_kept", {5'd0, fails_o}, 8'd1);

    wrong(7'h12);
    check("fails2", {5'd0, fails_o}, 8'd2);
    press(1'b0, 1'b1, 7'h00);
    wrong(7'h13);
    check("lockout_state", {5'd0, state_o}, {5'd0, LOCKOUT});
    check("lockout_fails", {5'd0, fails_o}, 8'd3);
    check("lockout_alarm", {7'd0, alarm_o}, 8'd1);
    press(1'b0, 1'b1, 7'h2A);
    check("lockout_ignore", {5'd0, state_o}, {5'd0, LOCKOUT});
    ticks(13);
    check("lockout_c19", {5'd0, state_o}, {5'd0, LOCKOUT});
    check("lockout_c19_alarm", {7'd0, alarm_o}, 8'd1);
    ticks(1);
    check("lockout_expire", {5'd0, state_o}, {5'd0, IDLE});
    check("lockout_clr_fails", {5'd0, fails_o}, 8'd0);
    check("lockout_alarm_off", {7'd0, alarm_o}, 8'd0);

    // Simultaneous SET+ENTER in OPENED: ENTER wins, password kept.
    press(1'b0, 1'b1, 7'h00);
    press(1'b0, 1'b1, 7'h2A);
    check("reopen", {5'd0, state_o}, {5'd0, OPENED});
    press(1'b1, 1'b1, 7'h33);
    check("both_enter_wins", {5'd0, state_o}, {5'd0, IDLE});
    press(1'b0, 1'b1, 7'h00);
    press(1'b0, 1'b1, 7'h2A);
    check("pw_unchanged", {5'd0, state_o}, {5'd0, OPENED});

    ena = 1'b0;
    press(1'b0, 1'b1, 7'h00);
    check("ena_low_drop", {5'd0, state_o}, {5'd0, OPENED});
    ena = 1'b1;
    press(1'b0, 1'b1, 7'h00);
    check("ena_back", {5'd0, state_o}, {5'd0, IDLE});

    press(1'b0, 1'b1, 7'h00);
    press(1'b0, 1'b1, 7'h2A);
    ticks(29);
    check("relock_c29", {5'd0, state_o}, {5'd0, OPENED});
    ticks(1);
`ifdef LOCK_SEQ_AUTORELOCK_EN
    check("relock_c30", {5'd0, state_o}, {5'd0, IDLE});
`else
    check("hold_c30", {5'd0, state_o}, {5'd0, OPENED});
    press(1'b0, 1'b1, 7'h00);
`endif
    check("relock_pw_kept", {7'd0, pw_valid_o}, 8'd1);

    // Reset in the middle of a lockout.
    wrong(7'h01);
    press(1'b0, 1'b1, 7'h00);
    wrong(7'h02);
    press(1'b0, 1'b1, 7'h00);
    wrong(7'h03);
    check("lockout2", {5'd0, state_o}, {5'd0, LOCKOUT});
    ticks(5);
    rst_n = 1'b0;
    #1;
    check("midrst_state", {5'd0, state_o}, {5'd0, IDLE});
    check("midrst_pwvalid", {7'd0, pw_valid_o}, 8'd0);
    check("midrst_fails", {5'd0, fails_o}, 8'd0);
    check("midrst_alarm", {7'd0, alarm_o}, 8'd0);
    ticks(2);
    rst_n = 1'b1;
    press(1'b0, 1'b1, 7'h00);
    press(1'b0, 1'b1, 7'h55);
    check("pw_lost_open", {5'd0, state_o}, {5'd0, OPENED});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
